// File: rtl/torus_mesh_engine_if.sv
// Load/control/status bundle for torus_mesh_engine; master drives loads and start, slave is the mesh.
// No storage here: latency and backpressure are set by the engine (ld_ready drops while start is high or outside IDLE).
interface torus_mesh_engine_if #(
   parameter int ROWS    = 18,
   parameter int COLS    = 26,
   parameter int STATE_W = 2,
   parameter int GEN_W   = 16
);
   logic                          cfg_wrap;
   logic                          ld_valid;
   logic                          ld_ready;
   logic [STATE_W*COLS-1:0]       ld_data;
   logic                          start;
   logic [GEN_W-1:0]              max_gen;
   logic                          busy;
   logic                          done;
   logic                          converged;
   logic [GEN_W-1:0]              gen_count;
   logic [STATE_W*ROWS*COLS-1:0]  state_flat;
   logic [ROWS*COLS-1:0]          out;

   modport master (
      output cfg_wrap, ld_valid, ld_data, start, max_gen,
      input  ld_ready, busy, done, converged, gen_count, state_flat, out
   );

   modport slave (
      input  cfg_wrap, ld_valid, ld_data, start, max_gen,
      output ld_ready, busy, done, converged, gen_count, state_flat, out
   );
endinterface

// File: rtl/torus_mesh_engine.sv
// ROWS x COLS cell mesh, row-loaded in IDLE, evolving one generation per clock under a 4-neighbour majority rule.
// Latency: one clock per row beat and per generation; ld_ready is low outside IDLE and while start is asserted.
module torus_mesh_engine #(
   parameter int ROWS    = 18,
   parameter int COLS    = 26,
   parameter int STATE_W = 2,
   parameter int GEN_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   torus_mesh_engine_if.slave    bus
);
   localparam int N        = ROWS * COLS;
   localparam int RW       = $clog2(ROWS);
   localparam int ROW_BITS = STATE_W * COLS;
   localparam logic [STATE_W-1:0] SMAX = '1;
   localparam logic [RW-1:0]      LAST_ROW = RW'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t                  state_q;
   logic [STATE_W*N-1:0]  cells_q;
   logic [STATE_W*N-1:0]  cells_nxt;
   logic [N-1:0]          lmax;
   logic [N-1:0]          out_q;
   logic [RW-1:0]         row_ptr;
   logic                  wrap_q;
   logic [GEN_W-1:0]      maxg_q;
   logic [GEN_W-1:0]      gen_q;
   logic [GEN_W-1:0]      gen_inc;
   logic                  busy_q;
   logic                  done_q;
   logic                  conv_q;
   logic                  changed;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         localparam int I  = r * COLS + c;
         localparam int IU = ((r + ROWS - 1) % ROWS) * COLS + c;
         localparam int ID = ((r + 1) % ROWS) * COLS + c;
         localparam int IL = r * COLS + (c + COLS - 1) % COLS;
         localparam int IR = r * COLS + (c + 1) % COLS;
         localparam logic IN_U = (r != 0);
         localparam logic IN_D = (r != ROWS - 1);
         localparam logic IN_L = (c != 0);
         localparam logic IN_R = (c != COLS - 1);

         logic [STATE_W-1:0] self;
         logic [STATE_W-1:0] nb [4];
         logic [3:0]         pres;
         logic [2:0]         gt;
         logic [2:0]         lt;
         logic               ge_all;
         logic [STATE_W-1:0] nxt;

         assign self  = cells_q[STATE_W*I  +: STATE_W];
         assign nb[0] = cells_q[STATE_W*IU +: STATE_W];
         assign nb[1] = cells_q[STATE_W*ID +: STATE_W];
         assign nb[2] = cells_q[STATE_W*IL +: STATE_W];
         assign nb[3] = cells_q[STATE_W*IR +: STATE_W];
         // Edge neighbours only drop out in bounded mode; in wrap mode every cell sees four.
         assign pres  = {wrap_q | IN_R, wrap_q | IN_L, wrap_q | IN_D, wrap_q | IN_U};

         always_comb begin
            gt     = '0;
            lt     = '0;
            ge_all = 1'b1;
            for (int k = 0; k < 4; k++) begin
               if (pres[k]) begin
                  if (nb[k] > self) begin
                     gt     = gt + 3'd1;
                     ge_all = 1'b0;
                  end
                  if (nb[k] < self) lt = lt + 3'd1;
               end
            end
            nxt = self;
            if (gt > lt && self != SMAX)  nxt = self + STATE_W'(1);
            if (lt > gt && self != '0)    nxt = self - STATE_W'(1);
         end

         assign cells_nxt[STATE_W*I +: STATE_W] = nxt;
         assign lmax[I] = ge_all;
      end
   end

   assign changed = (cells_nxt != cells_q);
   assign gen_inc = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cells_q <= '0;
         out_q   <= '0;
         row_ptr <= '0;
         wrap_q  <= 1'b0;
         maxg_q  <= '0;
         gen_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         conv_q  <= 1'b0;
      end else begin
         out_q  <= lmax;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  wrap_q  <= bus.cfg_wrap;
                  maxg_q  <= bus.max_gen;
                  gen_q   <= '0;
                  conv_q  <= 1'b0;
                  row_ptr <= '0;
                  if (bus.max_gen == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end else if (bus.ld_valid) begin
                  cells_q[ROW_BITS*row_ptr +: ROW_BITS] <= bus.ld_data;
                  row_ptr <= (row_ptr == LAST_ROW) ? '0 : row_ptr + RW'(1);
               end
            end
            RUN: begin
               cells_q <= cells_nxt;
               gen_q   <= gen_inc;
               if (!changed || gen_inc == maxg_q) begin
                  conv_q  <= !changed;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ld_ready   = (state_q == IDLE) && !bus.start;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.converged  = conv_q;
   assign bus.gen_count  = gen_q;
   assign bus.state_flat = cells_q;
   assign bus.out        = out_q;
endmodule
